matrix_result_tx: RTL and testbench

MATRIX_RESULT_TX -- requirements
Module: matrix_result_tx

---
 rtl/matrix_result_tx_if.sv | 33 +++
 rtl/matrix_result_tx.sv | 187 ++++++++++++++++++
 tb/tb_matrix_result_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_result_tx_if.sv
// Signal bundle between the matrix multiplier result side and the UART
// result transmitter.
//   c0..c8 : 3x3 result matrix, row-major, one byte per element
//   done   : multiplier completion flag (only its rising edge matters)
//   tx     : UART serial line, 8N1, idle high
//   busy   : high while a 9-byte dump is in progress
//   sent   : one-cycle pulse when the last stop bit has completed
// master drives the matrix and done; slave is the transmitter.
interface matrix_result_tx_if;
  logic [7:0] c0;
  logic [7:0] c1;
  logic [7:0] c2;
  logic [7:0] c3;
  logic [7:0] c4;
  logic [7:0] c5;
  logic [7:0] c6;
  logic [7:0] c7;
  logic [7:0] c8;
  logic       done;
  logic       tx;
  logic       busy;
  logic       sent;

  modport master (
    output c0, c1, c2, c3, c4, c5, c6, c7, c8, done,
    input  tx, busy, sent
  );

  modport slave (
    input  c0, c1, c2, c3, c4, c5, c6, c7, c8, done,
    output tx, busy, sent
  );
endinterface

// File: rtl/matrix_result_tx.sv
// Serialises a 3x3 byte matrix over a UART line (8N1, LSB first) when the
// multiplier's done flag rises. The matrix is snapshotted on the accepting
// edge, then c0..c8 are sent back to back with no idle gap between frames.
// Ports:
//   clk : clock, all state updates on its rising edge
//   rst : asynchronous active-low reset
//   bus : matrix_result_tx_if.slave (c0..c8, done in; tx, busy, sent out)
// Parameter CLKS_PER_BIT (>= 2) sets clock cycles per UART bit.
module matrix_result_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_result_tx_if.slave    bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [3:0]    byte_idx, byte_nx;
  logic          tx_reg, tx_nx;
  logic          busy_reg, busy_nx;
  logic          sent_reg, sent_nx;
  logic          done_d;
  logic          rise;
  logic          term;
  logic          capture;
  logic [7:0]    mat [0:8];
  logic [7:0]    in_mat [0:8];
  logic [7:0]    cur_byte;

  assign rise = bus.done & ~done_d;
  assign term = (cnt == TERM);

  assign bus.tx   = tx_reg;
  assign bus.busy = busy_reg;
  assign bus.sent = sent_reg;

  // Gather the interface bytes into an indexable array.
  always_comb begin
    in_mat[0] = bus.c0;
    in_mat[1] = bus.c1;
    in_mat[2] = bus.c2;
    in_mat[3] = bus.c3;
    in_mat[4] = bus.c4;
    in_mat[5] = bus.c5;
    in_mat[6] = bus.c6;
    in_mat[7] = bus.c7;
    in_mat[8] = bus.c8;
  end

  // Select the byte currently being serialised; out-of-range index sends zeros.
  always_comb begin
    if (byte_idx <= 4'd8) begin
      cur_byte = mat[byte_idx];
    end else begin
      cur_byte = 8'd0;
    end
  end

  // Next-state and next-output logic. Outputs are computed one cycle ahead so
  // that tx/busy/sent can come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    tx_nx    = tx_reg;
    busy_nx  = busy_reg;
    sent_nx  = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          capture  = 1'b1;
          state_nx = START;
          cnt_nx   = '0;
          bit_nx   = 3'd0;
          byte_nx  = 4'd0;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
        end else begin
          tx_nx    = 1'b1;
          busy_nx  = 1'b0;
        end
      end
      START: begin
        if (term) begin
          cnt_nx   = '0;
          bit_nx   = 3'd0;
          state_nx = DATA;
          tx_nx    = cur_byte[0];
        end else begin
          cnt_nx   = cnt + CW'(1);
        end
      end
      DATA: begin
        if (term) begin
          cnt_nx = '0;
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_nx   = bit_idx + 3'd1;
            tx_nx    = cur_byte[bit_idx + 3'd1];
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      STOP: begin
        if (term) begin
          cnt_nx = '0;
          if (byte_idx < 4'd8) begin
            // Next frame starts immediately: stop bit flows into start bit.
            byte_nx  = byte_idx + 4'd1;
            state_nx = START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
            sent_nx  = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        bit_nx   = 3'd0;
        byte_nx  = 4'd0;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // FSM, counters, edge-detect and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 4'd0;
      tx_reg   <= 1'b1;
      busy_reg <= 1'b0;
      sent_reg <= 1'b0;
      done_d   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      tx_reg   <= tx_nx;
      busy_reg <= busy_nx;
      sent_reg <= sent_nx;
      done_d   <= bus.done;
    end
  end

  // Matrix snapshot, taken only on the accepting edge so later input changes
  // cannot corrupt a dump in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin
        mat[i] <= 8'd0;
      end
    end else if (capture) begin
      for (int i = 0; i < 9; i++) begin
        mat[i] <= in_mat[i];
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
module tb_matrix_result_tx;

  localparam int N     = 4;
  localparam int FRAME = 10 * N;
  localparam int DUMP  = 90 * N;

  typedef struct {
    logic [7:0] c   [9];
    logic [7:0] exp [9];
    int         mode;
    bit         chained;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic trace [0:511];

  matrix_result_tx_if bus ();

  matrix_result_tx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_c(input logic [7:0] v [9]);
    bus.c0 = v[0]; bus.c1 = v[1]; bus.c2 = v[2];
    bus.c3 = v[3]; bus.c4 = v[4]; bus.c5 = v[5];
    bus.c6 = v[6]; bus.c7 = v[7]; bus.c8 = v[8];
  endtask

  // Reference line model: t cycles after E0, returns {tx, busy, sent}.
  function automatic logic [2:0] model(input logic [7:0] b [9], input int t);
    int k;
    int p;
    logic bitv;
    if (t < DUMP) begin
      k = t / FRAME;
      p = (t % FRAME) / N;
      if (p == 0)      bitv = 1'b0;
      else if (p == 9) bitv = 1'b1;
      else             bitv = b[k][p-1];
      return {bitv, 1'b1, 1'b0};
    end else if (t == DUMP) begin
      return 3'b101;
    end else begin
      return 3'b100;
    end
  endfunction

  // mode 0 normal, 1 corrupt inputs after E0, 2 done held high with an extra
  // rise at E0+100, 3 raise done in the sent cycle (back-to-back), 4 abort by
  // reset during byte 4. chained: E0 was already triggered by the caller.
  task automatic check_dump(input logic [7:0] exp [9], input int mode, input bit chained);
    int   last;
    bit   aborted;
    logic [2:0] got;
    logic [7:0] d;
    if (!chained) begin
      @(negedge clk);
      bus.done = 1'b1;
    end
    @(negedge clk);
    if (mode != 2) bus.done = 1'b0;
    last    = (mode == 3) ? DUMP : DUMP + 1;
    aborted = 1'b0;
    for (int t = 0; t <= last && !aborted; t++) begin
      if (t > 0) @(negedge clk);
      got = {bus.tx, bus.busy, bus.sent};
      trace[t] = bus.tx;
      chk($sformatf("line_t%0d", t), 32'(got), 32'(model(exp, t)));
      if (mode == 1 && t == 0) begin
        bus.c0 = 8'hFF; bus.c1 = 8'hFF; bus.c2 = 8'hFF;
        bus.c3 = 8'hFF; bus.c4 = 8'hFF; bus.c5 = 8'hFF;
        bus.c6 = 8'hFF; bus.c7 = 8'hFF; bus.c8 = 8'hFF;
      end
      if (mode == 2 && t == 98) bus.done = 1'b0;
      if (mode == 2 && t == 99) bus.done = 1'b1;
      if (mode == 3 && t == DUMP) bus.done = 1'b1;
      if (mode == 4 && t == 4 * FRAME + 3 * N) begin
        rst = 1'b0;
        #1;
        chk("abort_async", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));
        aborted = 1'b1;
      end
    end
    if (mode != 4) begin
      for (int k = 0; k < 9; k++) begin
        for (int b = 0; b < 8; b++) begin
          d[b] = trace[k * FRAME + N * (1 + b) + N / 2];
        end
        chk($sformatf("decode_byte%0d", k), 32'(d), 32'(exp[k]));
        chk($sformatf("framing_byte%0d", k),
            32'({trace[k * FRAME + N / 2], trace[k * FRAME + 9 * N + N / 2]}), 32'(2'b01));
      end
    end
  endtask

  vec_t       tbl [5];
  logic [7:0] m   [9];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.done = 1'b0;
    for (int i = 0; i < 9; i++) m[i] = 8'd0;
    set_c(m);

    tbl[0].c   = '{8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54, 8'd138, 8'd114, 8'd90};
    tbl[0].exp = '{8'h1E, 8'h18, 8'h12, 8'h54, 8'h45, 8'h36, 8'h8A, 8'h72, 8'h5A};
    tbl[0].mode = 0; tbl[0].chained = 1'b0;
    tbl[1].c   = tbl[0].c;
    tbl[1].exp = tbl[0].exp;
    tbl[1].mode = 1; tbl[1].chained = 1'b0;
    tbl[2].c   = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h0F, 8'hF0, 8'h7E};
    tbl[2].exp = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h0F, 8'hF0, 8'h7E};
    tbl[2].mode = 3; tbl[2].chained = 1'b0;
    tbl[3].c   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    tbl[3].exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    tbl[3].mode = 0; tbl[3].chained = 1'b1;
    tbl[4].c   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4].exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4].mode = 0; tbl[4].chained = 1'b0;

    // Reset with clock running and done toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_out", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));
      bus.done = ~bus.done;
    end
    bus.done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));

    for (int i = 0; i < 5; i++) begin
      set_c(tbl[i].c);
      check_dump(tbl[i].exp, tbl[i].mode, tbl[i].chained);
    end

    // Random matrices.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) m[i] = 8'($urandom_range(0, 255));
      set_c(m);
      check_dump(m, 0, 1'b0);
    end

    // Done held high for ~1000 cycles with an extra rise mid-dump.
    set_c(tbl[3].c);
    check_dump(tbl[3].exp, 2, 1'b0);
    for (int i = 0; i < 1000 - DUMP - 3; i++) begin
      @(negedge clk);
      chk("level_no_redump", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));
    end
    bus.done = 1'b0;
    @(negedge clk);

    // Abort during byte 4, then a fresh dump starting at c0.
    for (int i = 0; i < 9; i++) m[i] = 8'($urandom_range(0, 255));
    set_c(m);
    check_dump(m, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_held", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_dump(m, 0, 1'b0);

    // done already high at the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    bus.done = 1'b1;
    @(negedge clk);
    chk("reset_done_high", 32'({bus.tx, bus.busy, bus.sent}), 32'(3'b100));
    rst = 1'b1;
    check_dump(m, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
